clock_timekeeper: RTL and testbench
===================================

CLOCK_TIMEKEEPER -- requirements
Module: clock_timekeeper

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, meaning i_clk cycles per second (at least 2).
REQ-002 SHALL have port i_clk  in  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port i_reset_n  in  1  reset; the block has one clock, and this reset is asynchronous and active-low.
REQ-004 SHALL have port i_ena  in  1  global enable; when 0, all state is frozen and all pulses are ignored.
REQ-005 SHALL have port i_wr  in  1  set mode; 1 = time is editable and timekeeping is stopped.
REQ-006 SHALL have port i_input_pulse  in  1  one-cycle strobe that advances the selected field.
REQ-007 SHALL have port i_inc_pulse  in  1  one-cycle strobe that increments the selected field.
REQ-008 SHALL have port i_dec_pulse  in  1  one-cycle strobe that decrements the selected field.
REQ-009 SHALL have port o_clock_pulse  out  1  one-cycle strobe asserted at each second tick.
REQ-010 SHALL have port o_hh  out  8  hours in packed BCD, tens in [7:4], range 01..12.
REQ-011 SHALL have port o_mm  out  8  minutes in packed BCD, range 00..59.
REQ-012 SHALL have port o_ss  out  8  seconds in packed BCD, range 00..59.
REQ-013 SHALL have port o_pm  out  1  meridiem; 1 = PM.
REQ-014 SHALL have port o_sel  out  2  selected field: 0 = hh, 1 = mm, 2 = ss, 3 = pm.

Function
REQ-015 SHALL, when i_ena=1 and i_wr=0, run a prescaler 0..CLK_HZ-1; at terminal count it SHALL wrap to 0 and the time SHALL advance by 1 s.
REQ-016 SHALL assert o_clock_pulse for exactly one cycle, registered, in the same cycle the new time first appears on outputs.
REQ-017 SHALL carry seconds 59->00 into minutes, and minutes 59->00 into hours.
REQ-018 SHALL roll hours 11:59:59 -> 12:00:00 and toggle o_pm on that rollover.
REQ-019 SHALL roll hours 12:59:59 -> 01:00:00 with o_pm unchanged.
REQ-020 SHALL keep every BCD digit in 0..9 at all times; o_hh SHALL never show 00 or greater than 12.
REQ-021 SHALL, while i_wr=1, hold the prescaler at 0, never assert o_clock_pulse, and keep the time static except for edits.
REQ-022 SHALL, on i_input_pulse with i_wr=1, cycle o_sel 0->1->2->3->0.
REQ-023 SHALL apply i_inc_pulse with i_wr=1 to the selected field with wrap-around: hh 12->01, mm/ss 59->00, pm toggles.
REQ-024 SHALL apply i_dec_pulse with i_wr=1 to the selected field with wrap-around: hh 01->12, mm/ss 00->59, pm toggles.
REQ-025 SHALL NOT change o_pm or any other field as a side effect of editing hh, mm or ss (no carries in set mode).
REQ-026 SHALL ignore both strobes when i_inc_pulse and i_dec_pulse are asserted in the same cycle.
REQ-027 SHALL apply inc/dec to the pre-update selection when a strobe coincides with i_input_pulse; o_sel still advances that cycle.
REQ-028 SHALL ignore i_input_pulse, i_inc_pulse and i_dec_pulse while i_wr=0.
REQ-029 SHALL, on the i_wr 1->0 transition, reset o_sel to 0 and start the prescaler from 0, so the first tick comes CLK_HZ cycles later.
REQ-030 SHALL, when i_ena=0, hold the prescaler, time, o_sel and o_pm, and force o_clock_pulse to 0.
REQ-031 SHALL drive all outputs from registers, with no combinational path from inputs to outputs.

Reset
REQ-032 SHALL, while i_reset_n=0, immediately force o_hh=8'h12, o_mm=8'h00, o_ss=8'h00, o_pm=0, o_sel=0, o_clock_pulse=0, and prescaler=0.
REQ-033 SHALL, when reset asserts mid-operation (including in set mode or during a tick cycle), discard all state and produce no pulse.
REQ-034 SHALL begin counting on the first clock edge after i_reset_n deasserts.

Verification (CLK_HZ=4)
REQ-035 SHALL cover: reset release, i_ena=1, i_wr=0, 8 cycles -> o_clock_pulse high for one cycle at cycle 4 and at cycle 8; o_ss=8'h02.
REQ-036 SHALL cover: preset 11:59:59 AM, then 1 tick -> 12:00:00, o_pm=1; preset 12:59:59 PM, then 1 tick -> 01:00:00, o_pm=1.
REQ-037 SHALL cover: i_wr=1, sel=hh at 12, then inc -> 8'h01, then dec twice -> 8'h12 then 8'h11; o_pm unchanged throughout.
REQ-038 SHALL cover: i_wr=1, input_pulse x3 -> o_sel=3; then inc -> o_pm toggles; then input_pulse -> o_sel=0; inc and dec in the same cycle -> no change.
REQ-039 SHALL cover: sel=mm at 00, dec together with input_pulse -> o_mm=8'h59 and o_sel=2; then i_wr->0 -> o_sel=0 and first tick 4 cycles later.
REQ-040 SHALL cover: i_ena=0 for 10 cycles mid-count -> outputs frozen, no pulse; re-enable -> prescaler resumes from its held value; i_reset_n low mid-count -> 12:00:00 AM immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/clock_timekeeper_if.sv
// Control strobes into and time display out of the 12-hour timekeeper.
interface clock_timekeeper_if;
  logic       i_ena;
  logic       i_wr;
  logic       i_input_pulse;
  logic       i_inc_pulse;
  logic       i_dec_pulse;
  logic       o_clock_pulse;
  logic [7:0] o_hh;
  logic [7:0] o_mm;
  logic [7:0] o_ss;
  logic       o_pm;
  logic [1:0] o_sel;

  modport master (
    output i_ena, i_wr, i_input_pulse, i_inc_pulse, i_dec_pulse,
    input  o_clock_pulse, o_hh, o_mm, o_ss, o_pm, o_sel
  );

  modport slave (
    input  i_ena, i_wr, i_input_pulse, i_inc_pulse, i_dec_pulse,
    output o_clock_pulse, o_hh, o_mm, o_ss, o_pm, o_sel
  );
endinterface

// File: rtl/clock_timekeeper.sv
// 12-hour BCD time-of-day keeper with a one-second prescaler and a set mode
// for editing hh/mm/ss/meridiem through inc/dec/advance strobes.
module clock_timekeeper #(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input logic              i_clk,
  input logic              i_reset_n,
  clock_timekeeper_if.slave bus
);

  localparam int unsigned PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_TC  = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRE_ONE = PW'(1);

  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    hh_q, hh_d;
  logic [7:0]    mm_q, mm_d;
  logic [7:0]    ss_q, ss_d;
  logic          pm_q, pm_d;
  logic [1:0]    sel_q, sel_d;
  logic          pulse_q, pulse_d;

  function automatic logic [7:0] inc60(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h59)             r = 8'h00;
    else if (v[3:0] == 4'd9)    r = {v[7:4] + 4'd1, 4'd0};
    else                        r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] dec60(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h00)             r = 8'h59;
    else if (v[3:0] == 4'd0)    r = {v[7:4] - 4'd1, 4'd9};
    else                        r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  // Hours live in 01..12; 09<->10 is the only tens-digit crossing.
  function automatic logic [7:0] inc12(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h12)             r = 8'h01;
    else if (v == 8'h09)        r = 8'h10;
    else                        r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] dec12(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h01)             r = 8'h12;
    else if (v == 8'h10)        r = 8'h09;
    else                        r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  always_comb begin
    pre_d   = pre_q;
    hh_d    = hh_q;
    mm_d    = mm_q;
    ss_d    = ss_q;
    pm_d    = pm_q;
    sel_d   = sel_q;
    pulse_d = 1'b0;
    if (bus.i_ena) begin
      if (bus.i_wr) begin
        pre_d = '0;
        if (bus.i_input_pulse) sel_d = sel_q + 2'd1;
        // Edits act on the selection held before this cycle's advance.
        if (bus.i_inc_pulse ^ bus.i_dec_pulse) begin
          unique case (sel_q)
            2'd0: hh_d = bus.i_inc_pulse ? inc12(hh_q) : dec12(hh_q);
            2'd1: mm_d = bus.i_inc_pulse ? inc60(mm_q) : dec60(mm_q);
            2'd2: ss_d = bus.i_inc_pulse ? inc60(ss_q) : dec60(ss_q);
            2'd3: pm_d = ~pm_q;
          endcase
        end
      end else begin
        sel_d = 2'd0;
        if (pre_q == PRE_TC) begin
          pre_d   = '0;
          pulse_d = 1'b1;
          ss_d    = inc60(ss_q);
          if (ss_q == 8'h59) begin
            mm_d = inc60(mm_q);
            if (mm_q == 8'h59) begin
              hh_d = inc12(hh_q);
              if (hh_q == 8'h11) pm_d = ~pm_q;
            end
          end
        end else begin
          pre_d = pre_q + PRE_ONE;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pre_q   <= '0;
      hh_q    <= 8'h12;
      mm_q    <= 8'h00;
      ss_q    <= 8'h00;
      pm_q    <= 1'b0;
      sel_q   <= 2'd0;
      pulse_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      hh_q    <= hh_d;
      mm_q    <= mm_d;
      ss_q    <= ss_d;
      pm_q    <= pm_d;
      sel_q   <= sel_d;
      pulse_q <= pulse_d;
    end
  end

  assign bus.o_clock_pulse = pulse_q;
  assign bus.o_hh          = hh_q;
  assign bus.o_mm          = mm_q;
  assign bus.o_ss          = ss_q;
  assign bus.o_pm          = pm_q;
  assign bus.o_sel         = sel_q;

endmodule

// File: tb/tb_clock_timekeeper.sv
// Scoreboard bench for clock_timekeeper at CLK_HZ=4: ticking, rollovers,
// set-mode editing, enable freeze and asynchronous reset.
module tb_clock_timekeeper;
  localparam int CLK_HZ = 4;

  logic i_clk     = 1'b0;
  logic i_reset_n = 1'b0;
  int   checks    = 0;
  int   errors    = 0;

  logic [26:0] sb_st    [$];
  logic        sb_pulse [$];

  clock_timekeeper_if tk_if ();

  clock_timekeeper #(.CLK_HZ(CLK_HZ)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .bus       (tk_if.slave)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [26:0] st(input logic [7:0] hh, input logic [7:0] mm,
                                     input logic [7:0] ss, input logic pm,
                                     input logic [1:0] sel);
    return {hh, mm, ss, pm, sel};
  endfunction

  function automatic logic [26:0] obs();
    return {tk_if.o_hh, tk_if.o_mm, tk_if.o_ss, tk_if.o_pm, tk_if.o_sel};
  endfunction

  task automatic step(input logic [2:0] s);
    tk_if.i_inc_pulse   = s[2];
    tk_if.i_dec_pulse   = s[1];
    tk_if.i_input_pulse = s[0];
    @(negedge i_clk);
    tk_if.i_inc_pulse   = 1'b0;
    tk_if.i_dec_pulse   = 1'b0;
    tk_if.i_input_pulse = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_reset_n           = 1'b0;
    tk_if.i_ena         = 1'b1;
    tk_if.i_wr          = 1'b0;
    tk_if.i_inc_pulse   = 1'b0;
    tk_if.i_dec_pulse   = 1'b0;
    tk_if.i_input_pulse = 1'b0;
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [26:0] e;
    repeat (2) @(negedge i_clk);
    sb_st.push_back(st(8'h12, 8'h00, 8'h00, 1'b0, 2'd0));
    e = sb_st.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", obs(), e);
    end
    checks++;
    if (tk_if.o_clock_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulse: got %b expected 0", tk_if.o_clock_pulse);
    end
  endtask

  task automatic test_count();
    logic        ep;
    logic [26:0] e;
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      sb_pulse.push_back(c == 4 || c == 8);
      @(negedge i_clk);
      ep = sb_pulse.pop_front();
      checks++;
      if (tk_if.o_clock_pulse !== ep) begin
        errors++;
        $display("FAIL count_pulse[%0d]: got %b expected %b", c, tk_if.o_clock_pulse, ep);
      end
    end
    sb_st.push_back(st(8'h12, 8'h00, 8'h02, 1'b0, 2'd0));
    e = sb_st.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL count_state: got %h expected %h", obs(), e);
    end
    // Reset lands while the tick pulse is high: no clock edge before the check.
    #2 i_reset_n = 1'b0;
    sb_st.push_back(st(8'h12, 8'h00, 8'h00, 1'b0, 2'd0));
    #1 e = sb_st.pop_front();
    checks++;
    if (obs() !== e || tk_if.o_clock_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_tick: got %h/%b expected %h/0", obs(), tk_if.o_clock_pulse, e);
    end
  endtask

  task automatic test_set_hh();
    logic [2:0]  stim [3];
    logic [26:0] expv [3];
    logic [26:0] e;
    logic        ep;
    stim = '{3'b100, 3'b010, 3'b010};
    expv = '{st(8'h01, 8'h00, 8'h00, 1'b0, 2'd0),
             st(8'h12, 8'h00, 8'h00, 1'b0, 2'd0),
             st(8'h11, 8'h00, 8'h00, 1'b0, 2'd0)};
    do_reset();
    tk_if.i_wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb_st.push_back(expv[i]);
      step(stim[i]);
      e = sb_st.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL set_hh[%0d]: got %h expected %h", i, obs(), e);
      end
    end
    for (int c = 1; c <= 8; c++) begin
      sb_pulse.push_back(1'b0);
      @(negedge i_clk);
      ep = sb_pulse.pop_front();
      checks++;
      if (tk_if.o_clock_pulse !== ep) begin
        errors++;
        $display("FAIL set_no_tick[%0d]: got %b expected %b", c, tk_if.o_clock_pulse, ep);
      end
    end
    sb_st.push_back(st(8'h11, 8'h00, 8'h00, 1'b0, 2'd0));
    e = sb_st.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL set_static: got %h expected %h", obs(), e);
    end
  endtask

  task automatic test_sel_pm();
    logic [2:0]  stim [6];
    logic [26:0] expv [6];
    logic [26:0] e;
    stim = '{3'b001, 3'b001, 3'b001, 3'b100, 3'b001, 3'b110};
    expv = '{st(8'h12, 8'h00, 8'h00, 1'b0, 2'd1),
             st(8'h12, 8'h00, 8'h00, 1'b0, 2'd2),
             st(8'h12, 8'h00, 8'h00, 1'b0, 2'd3),
             st(8'h12, 8'h00, 8'h00, 1'b1, 2'd3),
             st(8'h12, 8'h00, 8'h00, 1'b1, 2'd0),
             st(8'h12, 8'h00, 8'h00, 1'b1, 2'd0)};
    do_reset();
    tk_if.i_wr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sb_st.push_back(expv[i]);
      step(stim[i]);
      e = sb_st.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL sel_pm[%0d]: got %h expected %h", i, obs(), e);
      end
    end
    tk_if.i_ena = 1'b0;
    sb_st.push_back(st(8'h12, 8'h00, 8'h00, 1'b1, 2'd0));
    step(3'b101);
    e = sb_st.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL edit_while_disabled: got %h expected %h", obs(), e);
    end
    tk_if.i_ena = 1'b1;
  endtask

  task automatic test_coincident();
    logic [2:0]  stim [2];
    logic [26:0] expv [2];
    logic [26:0] e;
    logic        ep;
    stim = '{3'b001, 3'b011};
    expv = '{st(8'h12, 8'h00, 8'h00, 1'b0, 2'd1),
             st(8'h12, 8'h59, 8'h00, 1'b0, 2'd2)};
    do_reset();
    tk_if.i_wr = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sb_st.push_back(expv[i]);
      step(stim[i]);
      e = sb_st.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL coincident[%0d]: got %h expected %h", i, obs(), e);
      end
    end
    tk_if.i_wr = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      sb_pulse.push_back(c == 4);
      @(negedge i_clk);
      ep = sb_pulse.pop_front();
      checks++;
      if (tk_if.o_clock_pulse !== ep) begin
        errors++;
        $display("FAIL exit_set_pulse[%0d]: got %b expected %b", c, tk_if.o_clock_pulse, ep);
      end
      if (c == 1) begin
        checks++;
        if (tk_if.o_sel !== 2'd0) begin
          errors++;
          $display("FAIL exit_set_sel: got %0d expected 0", tk_if.o_sel);
        end
      end
    end
    sb_st.push_back(st(8'h12, 8'h59, 8'h01, 1'b0, 2'd0));
    e = sb_st.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL exit_set_state: got %h expected %h", obs(), e);
    end
  endtask

  task automatic test_rollover();
    logic [2:0]  stim_a [5];
    logic [26:0] exp_a  [5];
    logic [2:0]  stim_b [4];
    logic [26:0] exp_b  [4];
    logic [26:0] e;
    int          n;
    stim_a = '{3'b010, 3'b001, 3'b010, 3'b001, 3'b010};
    exp_a  = '{st(8'h11, 8'h00, 8'h00, 1'b0, 2'd0),
               st(8'h11, 8'h00, 8'h00, 1'b0, 2'd1),
               st(8'h11, 8'h59, 8'h00, 1'b0, 2'd1),
               st(8'h11, 8'h59, 8'h00, 1'b0, 2'd2),
               st(8'h11, 8'h59, 8'h59, 1'b0, 2'd2)};
    stim_b = '{3'b001, 3'b010, 3'b001, 3'b010};
    exp_b  = '{st(8'h12, 8'h00, 8'h00, 1'b1, 2'd1),
               st(8'h12, 8'h59, 8'h00, 1'b1, 2'd1),
               st(8'h12, 8'h59, 8'h00, 1'b1, 2'd2),
               st(8'h12, 8'h59, 8'h59, 1'b1, 2'd2)};
    do_reset();
    tk_if.i_wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sb_st.push_back(exp_a[i]);
      step(stim_a[i]);
      e = sb_st.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL preset_am[%0d]: got %h expected %h", i, obs(), e);
      end
    end
    sb_st.push_back(st(8'h12, 8'h00, 8'h00, 1'b1, 2'd0));
    tk_if.i_wr = 1'b0;
    n = 0;
    while (n < 8 && tk_if.o_clock_pulse !== 1'b1) begin
      @(negedge i_clk);
      n++;
    end
    e = sb_st.pop_front();
    checks++;
    if (n != 4 || obs() !== e) begin
      errors++;
      $display("FAIL roll_11_12: got %h after %0d cycles expected %h after 4", obs(), n, e);
    end
    tk_if.i_wr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sb_st.push_back(exp_b[i]);
      step(stim_b[i]);
      e = sb_st.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL preset_pm[%0d]: got %h expected %h", i, obs(), e);
      end
    end
    sb_st.push_back(st(8'h01, 8'h00, 8'h00, 1'b1, 2'd0));
    tk_if.i_wr = 1'b0;
    n = 0;
    while (n < 8 && tk_if.o_clock_pulse !== 1'b1) begin
      @(negedge i_clk);
      n++;
    end
    e = sb_st.pop_front();
    checks++;
    if (n != 4 || obs() !== e) begin
      errors++;
      $display("FAIL roll_12_01: got %h after %0d cycles expected %h after 4", obs(), n, e);
    end
  endtask

  task automatic test_ena_freeze();
    logic        ep;
    logic [26:0] e;
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      sb_pulse.push_back(c == 4);
      @(negedge i_clk);
      ep = sb_pulse.pop_front();
      checks++;
      if (tk_if.o_clock_pulse !== ep) begin
        errors++;
        $display("FAIL pre_freeze_pulse[%0d]: got %b expected %b", c, tk_if.o_clock_pulse, ep);
      end
    end
    tk_if.i_ena = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      sb_pulse.push_back(1'b0);
      @(negedge i_clk);
      ep = sb_pulse.pop_front();
      checks++;
      if (tk_if.o_clock_pulse !== ep) begin
        errors++;
        $display("FAIL frozen_pulse[%0d]: got %b expected %b", c, tk_if.o_clock_pulse, ep);
      end
    end
    sb_st.push_back(st(8'h12, 8'h00, 8'h01, 1'b0, 2'd0));
    e = sb_st.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL frozen_state: got %h expected %h", obs(), e);
    end
    // Prescaler was held at 2, so the tick is two cycles after re-enable.
    tk_if.i_ena = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      sb_pulse.push_back(c == 2);
      @(negedge i_clk);
      ep = sb_pulse.pop_front();
      checks++;
      if (tk_if.o_clock_pulse !== ep) begin
        errors++;
        $display("FAIL resume_pulse[%0d]: got %b expected %b", c, tk_if.o_clock_pulse, ep);
      end
    end
    sb_st.push_back(st(8'h12, 8'h00, 8'h02, 1'b0, 2'd0));
    step(3'b101);
    e = sb_st.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL strobes_in_run: got %h expected %h", obs(), e);
    end
    @(negedge i_clk);
    #2 i_reset_n = 1'b0;
    sb_st.push_back(st(8'h12, 8'h00, 8'h00, 1'b0, 2'd0));
    #1 e = sb_st.pop_front();
    checks++;
    if (obs() !== e || tk_if.o_clock_pulse !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got %h/%b expected %h/0", obs(), tk_if.o_clock_pulse, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tk_if.i_ena         = 1'b1;
    tk_if.i_wr          = 1'b0;
    tk_if.i_input_pulse = 1'b0;
    tk_if.i_inc_pulse   = 1'b0;
    tk_if.i_dec_pulse   = 1'b0;
    test_reset();
    test_count();
    test_set_hh();
    test_sel_pm();
    test_coincident();
    test_rollover();
    test_ena_freeze();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
